sdram_refresh: RTL and testbench

- Periodic auto-refresh scheduler for the SDRAM controller.
- Sits directly downstream of the power-up init sequencer and is enabled by its `initiated` flag.
- Counts the refresh interval and raises a request to the command arbiter.
- Once granted, drives the DRAM command bus itself: PALL, then one REF per owed refresh, honouring tRP/tRC, then releases the bus.

---
 rtl/sdram_refresh.sv | 174 +++++++++++++++++
 tb/tb_sdram_refresh.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_refresh.sv
// sdram_refresh: periodic SDRAM auto-refresh scheduler.
// Counts the refresh interval, requests the bus, then issues PALL + REF burst.
module sdram_refresh #(
  parameter int clock_frequency_mhz    = 100,
  parameter int refresh_interval_cycle = 781,
  parameter int tRP_cycle              = 3,
  parameter int tRC_cycle              = 9,
  parameter int max_pending            = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        initiated,
  output logic        refresh_request,
  input  logic        refresh_grant,
  output logic        refresh_busy,
  output logic        refresh_done,
  output logic        refresh_overflow,
  output logic [3:0]  pending_count,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CKE,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N
);

  if (clock_frequency_mhz < 1 || tRP_cycle < 1 || tRC_cycle < 1 ||
      max_pending < 1 || max_pending > 15 ||
      refresh_interval_cycle < 1) begin : g_param_check
    $error("sdram_refresh: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_PRECHARGE,
    S_WAIT_TRP,
    S_REFRESH,
    S_WAIT_TRC,
    S_DONE
  } state_t;

  localparam logic [15:0] IV_LAST  = 16'(refresh_interval_cycle - 1);
  localparam logic [15:0] TRP_LAST = 16'(tRP_cycle - 2);
  localparam logic [15:0] TRC_LAST = 16'(tRC_cycle - 2);
  localparam logic [3:0]  PEND_MAX = 4'(max_pending);

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PALL = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;

  state_t      r_state;
  state_t      w_state_nx;
  logic [15:0] r_interval;
  logic [15:0] w_interval_nx;
  logic [15:0] r_wait;
  logic [15:0] w_wait_nx;
  logic [3:0]  r_pending;
  logic [3:0]  w_pending_nx;
  logic        r_overflow;
  logic        w_overflow_nx;
  logic        r_grant;
  logic        r_request;
  logic        r_busy;
  logic        r_done;
  logic        r_a10;
  logic [3:0]  r_cmd;
  logic        w_tick;
  logic        w_pall;
  logic        w_ref;
  logic        w_busy_nx;

  always_comb begin
    w_tick        = initiated && (r_interval == IV_LAST);
    w_interval_nx = (initiated && !w_tick) ? r_interval + 16'd1 : 16'd0;
    w_state_nx    = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_pending != 4'd0) w_state_nx = S_REQUEST;
      end
      S_REQUEST: begin
        if (r_grant) w_state_nx = S_PRECHARGE;
      end
      S_PRECHARGE: begin
        w_state_nx = (tRP_cycle == 1) ? S_REFRESH : S_WAIT_TRP;
      end
      S_WAIT_TRP: begin
        if (r_wait == TRP_LAST) w_state_nx = S_REFRESH;
      end
      S_REFRESH: begin
        if (tRC_cycle > 1)
          w_state_nx = S_WAIT_TRC;
        else
          w_state_nx = (r_pending != 4'd0) ? S_REFRESH : S_DONE;
      end
      S_WAIT_TRC: begin
        if (r_wait == TRC_LAST)
          w_state_nx = (r_pending != 4'd0) ? S_REFRESH : S_DONE;
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    w_wait_nx = (w_state_nx == r_state) ? r_wait + 16'd1 : 16'd0;
    w_pall    = (w_state_nx == S_PRECHARGE);
    w_ref     = (w_state_nx == S_REFRESH);
    w_busy_nx = w_state_nx inside
                {S_PRECHARGE, S_WAIT_TRP, S_REFRESH, S_WAIT_TRC};

    // A tick arriving on a REF edge cancels out.
    w_pending_nx  = r_pending;
    w_overflow_nx = r_overflow;
    unique case ({w_tick, w_ref})
      2'b10: begin
        if (r_pending == PEND_MAX) w_overflow_nx = 1'b1;
        else w_pending_nx = r_pending + 4'd1;
      end
      2'b01: begin
        w_pending_nx = r_pending - 4'd1;
      end
      default: begin
        w_pending_nx = r_pending;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_interval <= 16'd0;
      r_wait     <= 16'd0;
      r_pending  <= 4'd0;
      r_overflow <= 1'b0;
      r_grant    <= 1'b0;
      r_request  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_a10      <= 1'b0;
      r_cmd      <= CMD_NOP;
    end else begin
      r_state    <= w_state_nx;
      r_interval <= w_interval_nx;
      r_wait     <= w_wait_nx;
      r_pending  <= w_pending_nx;
      r_overflow <= w_overflow_nx;
      r_grant    <= refresh_grant && r_request;
      r_request  <= (w_state_nx == S_REQUEST);
      r_busy     <= w_busy_nx;
      r_done     <= (w_state_nx == S_DONE);
      r_a10      <= w_pall;
      r_cmd      <= w_pall ? CMD_PALL : (w_ref ? CMD_REF : CMD_NOP);
    end
  end

  assign refresh_request  = r_request;
  assign refresh_busy     = r_busy;
  assign refresh_done     = r_done;
  assign refresh_overflow = r_overflow;
  assign pending_count    = r_pending;
  assign DRAM_ADDR        = {2'b00, r_a10, 10'd0};
  assign DRAM_BA          = 2'b00;
  assign DRAM_CKE         = 1'b1;
  assign DRAM_CS_N        = r_cmd[3];
  assign DRAM_RAS_N       = r_cmd[2];
  assign DRAM_CAS_N       = r_cmd[1];
  assign DRAM_WE_N        = r_cmd[0];

endmodule

// File: tb/tb_sdram_refresh.sv
// tb_sdram_refresh: directed timing scenarios plus random stimulus
// checked against a burst-timeline model of the refresh scheduler.
`timescale 1ns/1ps
module tb_sdram_refresh;

  localparam int RI   = 20;
  localparam int TRP  = 3;
  localparam int TRC  = 9;
  localparam int MAXP = 3;
  localparam logic [27:0] RST_VEC =
    {4'b0000, 4'd0, 13'd0, 2'd0, 1'b1, 4'b0111};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        initiated = 1'b0;
  logic        refresh_grant = 1'b0;
  logic        refresh_request;
  logic        refresh_busy;
  logic        refresh_done;
  logic        refresh_overflow;
  logic [3:0]  pending_count;
  logic [12:0] DRAM_ADDR;
  logic [1:0]  DRAM_BA;
  logic        DRAM_CKE;
  logic        DRAM_CS_N;
  logic        DRAM_RAS_N;
  logic        DRAM_CAS_N;
  logic        DRAM_WE_N;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sdram_refresh #(
    .clock_frequency_mhz   (100),
    .refresh_interval_cycle(RI),
    .tRP_cycle             (TRP),
    .tRC_cycle             (TRC),
    .max_pending           (MAXP)
  ) u_dut (
    .clock           (clock),
    .reset           (reset),
    .initiated       (initiated),
    .refresh_request (refresh_request),
    .refresh_grant   (refresh_grant),
    .refresh_busy    (refresh_busy),
    .refresh_done    (refresh_done),
    .refresh_overflow(refresh_overflow),
    .pending_count   (pending_count),
    .DRAM_ADDR       (DRAM_ADDR),
    .DRAM_BA         (DRAM_BA),
    .DRAM_CKE        (DRAM_CKE),
    .DRAM_CS_N       (DRAM_CS_N),
    .DRAM_RAS_N      (DRAM_RAS_N),
    .DRAM_CAS_N      (DRAM_CAS_N),
    .DRAM_WE_N       (DRAM_WE_N)
  );

  function automatic logic [27:0] dut_vec();
    return {refresh_request, refresh_busy, refresh_done,
            refresh_overflow, pending_count, DRAM_ADDR, DRAM_BA,
            DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
  endfunction

  function automatic bit is_pall();
    return {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} == 4'b0010
           && DRAM_ADDR == 13'h0400;
  endfunction

  function automatic bit is_ref();
    return {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} == 4'b0001
           && DRAM_ADDR == 13'h0000;
  endfunction

  // Reference model: interval from an age count, burst as a timeline
  // measured from the PALL cycle (REF at tRP, then every tRC).
  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_BURST = 2;
  localparam int M_DONE  = 3;

  int          m_age = 0;
  int          m_pend = 0;
  bit          m_ovf = 0;
  int          m_mode = M_IDLE;
  int          m_t = 0;
  bit          m_gr = 0;
  bit          m_refd = 0;
  logic [27:0] m_exp = RST_VEC;

  always @(posedge clock) begin : model
    bit tk;
    bit rf;
    int mn;
    int tn;
    if (reset) begin
      m_age = 0; m_pend = 0; m_ovf = 0;
      m_mode = M_IDLE; m_t = 0; m_gr = 0; m_refd = 0;
    end else begin
      tk = initiated && (m_age % RI == RI - 1);
      rf = 0;
      mn = m_mode;
      tn = m_t + 1;
      case (m_mode)
        M_IDLE: if (m_pend != 0) mn = M_REQ;
        M_REQ: if (m_gr) begin mn = M_BURST; tn = 0; end
        M_BURST: begin
          if (tn == TRP) rf = 1;
          else if (tn > TRP && (tn - TRP) % TRC == 0) begin
            if (m_pend != 0) rf = 1;
            else mn = M_DONE;
          end
        end
        default: mn = M_IDLE;
      endcase
      m_gr = refresh_grant && (m_mode == M_REQ);
      m_age = initiated ? m_age + 1 : 0;
      if (tk && !rf && m_pend == MAXP) m_ovf = 1;
      else m_pend = m_pend + int'(tk) - int'(rf);
      m_mode = mn;
      m_t = tn;
      m_refd = rf;
    end
    m_exp = {m_mode == M_REQ, m_mode == M_BURST, m_mode == M_DONE,
             m_ovf, 4'(m_pend),
             (m_mode == M_BURST && m_t == 0) ? 13'h0400 : 13'h0000,
             2'b00, 1'b1,
             (m_mode == M_BURST && m_t == 0) ? 4'b0010 :
             (m_refd ? 4'b0001 : 4'b0111)};
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    initiated = 1'b0;
    refresh_grant = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    initiated = 1'b1;
    refresh_grant = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (dut_vec() !== RST_VEC) begin
      miscompares++;
      $display("FAIL reset_held got=%h exp=%h", dut_vec(), RST_VEC);
    end
    reset = 1'b0;
    initiated = 1'b0;
    @(negedge clock);
    vectors++;
    if (dut_vec() !== RST_VEC) begin
      miscompares++;
      $display("FAIL reset_release got=%h exp=%h", dut_vec(), RST_VEC);
    end
  endtask

  task automatic test_single();
    int c0;
    int rel;
    int t_req = -1;
    int t_pall = -1;
    int t_ref = -1;
    int t_done = -1;
    int t_busy = -1;
    do_reset();
    initiated = 1'b1;
    refresh_grant = 1'b1;
    c0 = cyc;
    repeat (38) begin
      @(negedge clock);
      rel = cyc - c0;
      if (refresh_request && t_req < 0) t_req = rel;
      if (refresh_busy && t_busy < 0) t_busy = rel;
      if (is_pall() && t_pall < 0) t_pall = rel;
      if (is_ref() && t_ref < 0) t_ref = rel;
      if (refresh_done && t_done < 0) t_done = rel;
    end
    vectors++;
    if (t_req !== 21) begin
      miscompares++;
      $display("FAIL single_request_cycle got=%0d exp=21", t_req);
    end
    vectors++;
    if (t_pall !== 23) begin
      miscompares++;
      $display("FAIL single_pall_cycle got=%0d exp=23", t_pall);
    end
    vectors++;
    if (t_busy !== 23) begin
      miscompares++;
      $display("FAIL single_busy_cycle got=%0d exp=23", t_busy);
    end
    vectors++;
    if (t_ref !== 26) begin
      miscompares++;
      $display("FAIL single_ref_cycle got=%0d exp=26", t_ref);
    end
    vectors++;
    if (t_done !== 35) begin
      miscompares++;
      $display("FAIL single_done_cycle got=%0d exp=35", t_done);
    end
    vectors++;
    if (pending_count !== 4'd0) begin
      miscompares++;
      $display("FAIL single_pending_end got=%0d exp=0", pending_count);
    end
  endtask

  task automatic test_backlog();
    int c0;
    int rel;
    int n_pall = 0;
    int n_done = 0;
    int t_done = -1;
    int refs[$];
    do_reset();
    initiated = 1'b1;
    c0 = cyc;
    repeat (70) @(negedge clock);
    vectors++;
    if (pending_count !== 4'd3) begin
      miscompares++;
      $display("FAIL backlog_pending got=%0d exp=3", pending_count);
    end
    refresh_grant = 1'b1;
    repeat (52) begin
      @(negedge clock);
      rel = cyc - c0;
      if (is_pall()) n_pall++;
      if (is_ref()) refs.push_back(rel);
      if (refresh_done) begin n_done++; t_done = rel; end
    end
    vectors++;
    if (n_pall !== 1 || n_done !== 1) begin
      miscompares++;
      $display("FAIL backlog_pall_done got=%0d/%0d exp=1/1", n_pall, n_done);
    end
    vectors++;
    if (refs.size() !== 5) begin
      miscompares++;
      $display("FAIL backlog_ref_count got=%0d exp=5", refs.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (refs[i] !== 75 + 9 * i) begin
          miscompares++;
          $display("FAIL backlog_ref_time got=%0d exp=%0d",
                   refs[i], 75 + 9 * i);
        end
      end
    end
    vectors++;
    if (t_done !== 120) begin
      miscompares++;
      $display("FAIL backlog_done_cycle got=%0d exp=120", t_done);
    end
  endtask

  task automatic test_tick_ref();
    int c0;
    int rel;
    int n_ref = 0;
    int t_done = -1;
    logic [3:0] p39 = 4'hf;
    logic [3:0] p40 = 4'hf;
    bit ref40 = 0;
    do_reset();
    initiated = 1'b1;
    c0 = cyc;
    repeat (35) @(negedge clock);
    refresh_grant = 1'b1;
    repeat (23) begin
      @(negedge clock);
      rel = cyc - c0;
      if (rel == 39) p39 = pending_count;
      if (rel == 40) begin p40 = pending_count; ref40 = is_ref(); end
      if (is_ref()) n_ref++;
      if (refresh_done && t_done < 0) t_done = rel;
    end
    vectors++;
    if (!ref40 || p39 !== 4'd1 || p40 !== 4'd1) begin
      miscompares++;
      $display("FAIL tick_ref_pending got=%0d,%0d,ref=%0d exp=1,1,ref=1",
               p39, p40, ref40);
    end
    vectors++;
    if (n_ref !== 2 || t_done !== 58) begin
      miscompares++;
      $display("FAIL tick_ref_burst got=%0d refs,done@%0d exp=2,done@58",
               n_ref, t_done);
    end
  endtask

  task automatic test_overflow();
    int c0;
    bit seen_done = 0;
    do_reset();
    initiated = 1'b1;
    c0 = cyc;
    repeat (79) @(negedge clock);
    vectors++;
    if (refresh_overflow !== 1'b0 || pending_count !== 4'd3) begin
      miscompares++;
      $display("FAIL overflow_before got=%0d/%0d exp=0/3",
               refresh_overflow, pending_count);
    end
    @(negedge clock);
    vectors++;
    if (refresh_overflow !== 1'b1 || pending_count !== 4'd3) begin
      miscompares++;
      $display("FAIL overflow_set got=%0d/%0d exp=1/3",
               refresh_overflow, pending_count);
    end
    repeat (5) @(negedge clock);
    refresh_grant = 1'b1;
    while (cyc - c0 < 140) begin
      @(negedge clock);
      if (refresh_done) seen_done = 1;
    end
    vectors++;
    if (!seen_done || refresh_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky got=done%0d,ovf%0d exp=done1,ovf1",
               seen_done, refresh_overflow);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    int bad = 0;
    do_reset();
    initiated = 1'b1;
    refresh_grant = 1'b1;
    c0 = cyc;
    while (cyc - c0 < 27) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (dut_vec() !== RST_VEC) begin
      miscompares++;
      $display("FAIL reset_mid got=%h exp=%h", dut_vec(), RST_VEC);
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (is_ref() || is_pall() || refresh_busy) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet got=%0d exp=0", bad);
    end
  endtask

  task automatic test_gating();
    int bad = 0;
    do_reset();
    repeat (1000) begin
      refresh_grant = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (dut_vec() !== RST_VEC) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL gating got=%0d bad cycles exp=0", bad);
    end
  endtask

  task automatic test_random();
    int pct = 50;
    do_reset();
    initiated = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      vectors++;
      if (dut_vec() !== m_exp) begin
        miscompares++;
        if (miscompares <= 10)
          $display("FAIL random cyc=%0d got=%h exp=%h",
                   cyc, dut_vec(), m_exp);
      end
      if (i % 250 == 0) pct = $urandom_range(0, 100);
      refresh_grant = ($urandom_range(0, 99) < pct);
      initiated = ($urandom_range(0, 399) != 0);
      reset = ($urandom_range(0, 799) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backlog();
    test_tick_ref();
    test_overflow();
    test_reset_mid();
    test_gating();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
